snake_game_sched: RTL and testbench
===================================

# snake_game_sched

Game-flow scheduler for the snake design. Owns the START/PLAY/END state machine and drives `Game_status`. Generates the movement tick that paces the snake controller, detects apple eating and issues the body-grow and new-apple requests. Also tracks score and speed level and produces the END-screen flash. Sits between the key inputs, the snake controller, the apple generator and the display logic.

## Interface
Parameters:
- `TICK_BASE`, 6_000_000: initial move period in clock cycles (0.25 s at 24 MHz).
- `TICK_STEP`, 500_000: period reduction applied per speed-up.
- `TICK_MIN`, 2_000_000: floor for the move period.
- `PTS_PER_LEVEL`, 4: points between speed-ups.
- `FLASH_HALF`, 6_000_000: half-period of `Flash_sig` in END.
- `END_FLASHES`, 6: `Flash_sig` toggles before a restart key is accepted.
- `MAX_LEN`, 16: snake length that counts as a win.

Ports:
- `Clk_24mhz` in 1: system clock. One clock domain only.
- `Rst` in 1: reset. Synchronous and active-high.
- `Key_start` in 1: start/restart key, level, already debounced. The block edge-detects it internally.
- `Hit_wall_sig` in 1: wall collision flag from the snake controller.
- `Hit_body_sig` in 1: body collision flag from the snake controller.
- `Head` in 8: head cell as {X[3:0], Y[3:0]}.
- `Apple` in 8: apple cell as {X, Y}.
- `Apple_valid` in 1: apple generator currently holds a placed apple.
- `Snake_length` in 8: current length from the snake controller.
- `Game_status` out 3: 001 = START, 010 = PLAY, 100 = END. Always one-hot.
- `Move_tick` out 1: one-cycle pulse, one snake step.
- `Body_add_sig` out 1: one-cycle grow pulse.
- `Apple_req` out 1: one-cycle request for a new apple.
- `Score` out 8: apples eaten, saturates at 255.
- `Level` out 4: speed level, saturates at 15.
- `Win` out 1: set when the game ended by reaching `MAX_LEN`.
- `Flash_sig` out 1: blink in END, 0 otherwise.

## Operation
Reset values: `Game_status`=001, `Score`=0, `Level`=0, `Win`=0, `Flash_sig`=0, all pulse outputs 0, period register=`TICK_BASE`, all counters 0.

Start key: the block registers `Key_start`. A "press" is the registered value 0 together with the current value 1.

START:
- No ticks are issued.
- A press moves to PLAY.
- On that transition: `Score`, `Level` and `Win` clear, period reloads to `TICK_BASE`, the tick counter clears, and `Apple_req` pulses in the first PLAY cycle.

PLAY:
- The tick counter counts from 0 to period−1. At period−1 it pulses `Move_tick` and wraps to 0.
- Eat check runs only in the cycle immediately after `Move_tick`. Eat condition: `Apple_valid` && `Head`==`Apple`.
- On eat, in the same cycle: `Body_add_sig`=1, `Apple_req`=1, `Score`+1 (saturating).
- When the new `Score` is a nonzero multiple of `PTS_PER_LEVEL`: period = max(period−`TICK_STEP`, `TICK_MIN`) and `Level`+1 (saturating). The new period applies starting with the next count.
- Win: eat while `Snake_length`==`MAX_LEN`−1 sets `Win`=1 and moves to END on the next cycle. No `Apple_req` is issued on the winning eat.
- Collision: `Hit_wall_sig` or `Hit_body_sig` high in any PLAY cycle moves to END on the next edge.
- Collision has priority over eat in the same cycle: no `Body_add_sig`, no score change.

END:
- `Move_tick` is suppressed.
- The flash counter toggles `Flash_sig` every `FLASH_HALF` cycles.
- Key presses are ignored until `END_FLASHES` toggles have occurred. After that the flash keeps running.
- A press moves to START and forces `Flash_sig`=0.
- Hit inputs are ignored in END and START.

Reset mid-operation: `Rst` overrides every state on the next edge and restores all reset values.

## Timing
- `Game_status` is registered and updates one cycle after the triggering condition.
- `Move_tick` is high exactly 1 cycle per period. Spacing between ticks equals the current period in cycles.
- Eat decision latency: `Body_add_sig`/`Apple_req` assert exactly 1 cycle after `Move_tick`. `Score` updates on the same edge as that assertion.
- No pulse output is ever high for 2 consecutive cycles.
- All counters are 32-bit. The period register never goes below `TICK_MIN`. Subtraction is clamped, never wraps.

## Test plan
Bench parameters: `TICK_BASE`=20, `TICK_STEP`=4, `TICK_MIN`=12, `PTS_PER_LEVEL`=2, `FLASH_HALF`=5, `END_FLASHES`=2, `MAX_LEN`=5.

1. Reset, then hold `Key_start` high with no rising edge in view → stays 001 with no ticks. Release, press → 010 one cycle later, `Apple_req` pulse in the first PLAY cycle, `Move_tick` every 20 cycles.
2. Drive `Head`==`Apple` with `Apple_valid`=1 at two ticks → `Body_add_sig`/`Apple_req` 1 cycle after each tick, `Score`=2, `Level`=1, next tick spacing 16. Two more eats give spacing 12. Two further eats keep spacing at 12 (floor).
3. Raise `Hit_wall_sig` in the same cycle as an eat condition → END next cycle, `Score` unchanged, `Body_add_sig`=0.
4. With `Snake_length`=4, eat → `Win`=1, `Game_status`=100, no `Apple_req`.
5. In END, press after 1 toggle → ignored. `Flash_sig` period is 10 cycles. Press after 2 toggles → 001, `Flash_sig`=0.
6. Assert `Rst` mid-PLAY at tick count 7 → next cycle shows all reset values, and no `Move_tick` for at least the full `TICK_BASE` after the next start.

Source files
------------

// File: rtl/snake_game_sched_if.sv
// Signal bundle between the game scheduler and its neighbours (keys, snake controller,
// apple generator, display). The slave side is the scheduler itself.
`timescale 1ns/1ps
interface snake_game_sched_if;
    logic       Key_start;
    logic       Hit_wall_sig;
    logic       Hit_body_sig;
    logic [7:0] Head;
    logic [7:0] Apple;
    logic       Apple_valid;
    logic [7:0] Snake_length;
    logic [2:0] Game_status;
    logic       Move_tick;
    logic       Body_add_sig;
    logic       Apple_req;
    logic [7:0] Score;
    logic [3:0] Level;
    logic       Win;
    logic       Flash_sig;

    modport master (
        output Key_start, Hit_wall_sig, Hit_body_sig, Head, Apple, Apple_valid, Snake_length,
        input  Game_status, Move_tick, Body_add_sig, Apple_req, Score, Level, Win, Flash_sig
    );

    modport slave (
        input  Key_start, Hit_wall_sig, Hit_body_sig, Head, Apple, Apple_valid, Snake_length,
        output Game_status, Move_tick, Body_add_sig, Apple_req, Score, Level, Win, Flash_sig
    );
endinterface

// File: rtl/snake_game_sched.sv
// Snake game-flow scheduler: START/PLAY/END state machine, move tick generation,
// apple eating, score/level tracking and END-screen flash.
`timescale 1ns/1ps
module snake_game_sched #(
    parameter int unsigned TICK_BASE     = 6_000_000,
    parameter int unsigned TICK_STEP     = 500_000,
    parameter int unsigned TICK_MIN      = 2_000_000,
    parameter int unsigned PTS_PER_LEVEL = 4,
    parameter int unsigned FLASH_HALF    = 6_000_000,
    parameter int unsigned END_FLASHES   = 6,
    parameter int unsigned MAX_LEN       = 16
) (
    input  logic               Clk_24mhz,
    input  logic               Rst,
    snake_game_sched_if.slave  bus
);

    typedef enum logic [2:0] {
        StStart = 3'b001,
        StPlay  = 3'b010,
        StEnd   = 3'b100
    } state_e;

    state_e      state_q;
    logic        key_q;
    logic [31:0] tick_cnt_q;
    logic [31:0] period_q;
    logic [31:0] flash_cnt_q;
    logic [31:0] toggles_q;
    logic        move_tick_q;
    logic        body_add_q;
    logic        apple_req_q;
    logic        win_q;
    logic        flash_q;
    logic [7:0]  score_q;
    logic [3:0]  level_q;

    logic        press;
    logic        hit;
    logic        eat;
    logic        win_eat;
    logic        speed_up;
    logic [7:0]  score_inc;
    logic [31:0] period_dec;

    always_comb begin
        press     = bus.Key_start & ~key_q;
        hit       = bus.Hit_wall_sig | bus.Hit_body_sig;
        // Eating is only judged in the cycle right after a move step.
        eat       = move_tick_q & bus.Apple_valid & (bus.Head == bus.Apple);
        win_eat   = eat & (bus.Snake_length == 8'(MAX_LEN - 1));
        score_inc = (score_q == 8'hff) ? score_q : score_q + 8'd1;
        speed_up  = (score_q != 8'hff) && ((32'(score_inc) % PTS_PER_LEVEL) == 32'd0);
        period_dec = (period_q >= 32'(TICK_MIN + TICK_STEP)) ? period_q - 32'(TICK_STEP)
                                                             : 32'(TICK_MIN);
    end

    always_ff @(posedge Clk_24mhz) begin
        // Edge detector tracks the key even through reset so a held key is never a press.
        key_q <= bus.Key_start;
        if (Rst) begin
            state_q     <= StStart;
            tick_cnt_q  <= '0;
            period_q    <= 32'(TICK_BASE);
            flash_cnt_q <= '0;
            toggles_q   <= '0;
            move_tick_q <= 1'b0;
            body_add_q  <= 1'b0;
            apple_req_q <= 1'b0;
            win_q       <= 1'b0;
            flash_q     <= 1'b0;
            score_q     <= '0;
            level_q     <= '0;
        end else begin
            move_tick_q <= 1'b0;
            body_add_q  <= 1'b0;
            apple_req_q <= 1'b0;
            unique case (state_q)
                StStart: begin
                    flash_q <= 1'b0;
                    if (press) begin
                        state_q     <= StPlay;
                        score_q     <= '0;
                        level_q     <= '0;
                        win_q       <= 1'b0;
                        period_q    <= 32'(TICK_BASE);
                        tick_cnt_q  <= '0;
                        apple_req_q <= 1'b1;
                    end
                end
                StPlay: begin
                    if (hit) begin
                        state_q     <= StEnd;
                        flash_cnt_q <= '0;
                        toggles_q   <= '0;
                        flash_q     <= 1'b0;
                    end else begin
                        if (tick_cnt_q == period_q - 32'd1) begin
                            tick_cnt_q  <= '0;
                            move_tick_q <= 1'b1;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 32'd1;
                        end
                        if (eat) begin
                            body_add_q <= 1'b1;
                            score_q    <= score_inc;
                            if (speed_up) begin
                                period_q <= period_dec;
                                if (level_q != 4'hf) level_q <= level_q + 4'd1;
                            end
                            if (win_eat) begin
                                win_q       <= 1'b1;
                                state_q     <= StEnd;
                                flash_cnt_q <= '0;
                                toggles_q   <= '0;
                                flash_q     <= 1'b0;
                            end else begin
                                apple_req_q <= 1'b1;
                            end
                        end
                    end
                end
                StEnd: begin
                    if (press && (toggles_q >= 32'(END_FLASHES))) begin
                        state_q     <= StStart;
                        flash_q     <= 1'b0;
                        flash_cnt_q <= '0;
                    end else if (flash_cnt_q == 32'(FLASH_HALF - 1)) begin
                        flash_cnt_q <= '0;
                        flash_q     <= ~flash_q;
                        if (toggles_q < 32'(END_FLASHES)) toggles_q <= toggles_q + 32'd1;
                    end else begin
                        flash_cnt_q <= flash_cnt_q + 32'd1;
                    end
                end
                default: state_q <= StStart;
            endcase
        end
    end

    assign bus.Game_status  = state_q;
    assign bus.Move_tick    = move_tick_q;
    assign bus.Body_add_sig = body_add_q;
    assign bus.Apple_req    = apple_req_q;
    assign bus.Score        = score_q;
    assign bus.Level        = level_q;
    assign bus.Win          = win_q;
    assign bus.Flash_sig    = flash_q;

endmodule

// File: tb/tb_snake_game_sched.sv
// Self-checking bench for snake_game_sched: randomized eat/miss pattern against a
// score/level/period model, plus collision, win, END flash and mid-game reset scenarios.
`timescale 1ns/1ps
module tb_snake_game_sched;
    localparam int TB  = 20;
    localparam int TS  = 4;
    localparam int TM  = 12;
    localparam int PPL = 2;
    localparam int FH  = 5;
    localparam int EF  = 2;
    localparam int ML  = 5;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   stray = 0;
    int   exp_score;
    int   exp_level;
    int   exp_period;

    snake_game_sched_if bus();

    snake_game_sched #(
        .TICK_BASE(TB), .TICK_STEP(TS), .TICK_MIN(TM), .PTS_PER_LEVEL(PPL),
        .FLASH_HALF(FH), .END_FLASHES(EF), .MAX_LEN(ML)
    ) dut (
        .Clk_24mhz(clk),
        .Rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until Move_tick is seen; n = cycles waited, -1 on timeout.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
            if (bus.Body_add_sig || bus.Apple_req) stray++;
        end while (!bus.Move_tick && n < 200);
        if (!bus.Move_tick) n = -1;
    endtask

    task automatic press();
        bus.Key_start = 1'b0;
        step();
        bus.Key_start = 1'b1;
        step();
    endtask

    task automatic test_reset();
        int n;
        int ticks;
        int not_start;
        bus.Key_start = 1'b1; bus.Hit_wall_sig = 1'b0; bus.Hit_body_sig = 1'b0;
        bus.Head = 8'h11; bus.Apple = 8'h22; bus.Apple_valid = 1'b0; bus.Snake_length = 8'd2;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        total++; if (bus.Game_status !== 3'b001) begin bad++;
            $display("FAIL reset_status got=%b want=001", bus.Game_status); end
        total++; if (bus.Score !== 8'd0 || bus.Level !== 4'd0 || bus.Win !== 1'b0) begin bad++;
            $display("FAIL reset_regs got score=%0d level=%0d win=%b want 0/0/0",
                     bus.Score, bus.Level, bus.Win); end
        total++; if ({bus.Move_tick, bus.Body_add_sig, bus.Apple_req, bus.Flash_sig} !== 4'b0) begin
            bad++; $display("FAIL reset_pulses got=%b want=0000",
                {bus.Move_tick, bus.Body_add_sig, bus.Apple_req, bus.Flash_sig}); end
        ticks = 0; not_start = 0;
        repeat (30) begin
            step();
            if (bus.Move_tick) ticks++;
            if (bus.Game_status !== 3'b001) not_start++;
        end
        total++; if (ticks !== 0 || not_start !== 0) begin bad++;
            $display("FAIL held_key_idle got ticks=%0d nonstart=%0d want 0/0", ticks, not_start); end
        press();
        total++; if (bus.Game_status !== 3'b010 || bus.Apple_req !== 1'b1) begin bad++;
            $display("FAIL start_press got status=%b req=%b want 010/1",
                     bus.Game_status, bus.Apple_req); end
        stray = 0;
        wait_tick(n);
        total++; if (n !== TB) begin bad++;
            $display("FAIL first_tick got=%0d want=%0d", n, TB); end
        wait_tick(n);
        total++; if (n !== TB) begin bad++;
            $display("FAIL tick_spacing got=%0d want=%0d", n, TB); end
        total++; if (stray !== 0) begin bad++;
            $display("FAIL start_stray_pulses got=%0d want=0", stray); end
    endtask

    task automatic test_eat();
        int n;
        int eats;
        int not_play;
        logic do_eat;
        logic [7:0] a;
        exp_score = 0; exp_level = 0; exp_period = TB; eats = 0; stray = 0; not_play = 0;
        for (int it = 0; it < 40 && eats < 6; it++) begin
            do_eat = ($urandom_range(0, 3) != 0);
            a = 8'($urandom);
            bus.Apple = a;
            bus.Snake_length = 8'($urandom_range(1, 3));
            if (do_eat) begin
                bus.Head = a; bus.Apple_valid = 1'b1;
            end else if ($urandom_range(0, 1) != 0) begin
                bus.Head = a; bus.Apple_valid = 1'b0;
            end else begin
                bus.Head = a ^ 8'($urandom_range(1, 255)); bus.Apple_valid = 1'b1;
            end
            if (do_eat) begin
                eats++;
                exp_score = (exp_score < 255) ? exp_score + 1 : 255;
                if (exp_score % PPL == 0) begin
                    exp_level = (exp_level < 15) ? exp_level + 1 : 15;
                    exp_period = (exp_period - TS < TM) ? TM : exp_period - TS;
                end
            end
            step();
            total++; if (bus.Body_add_sig !== do_eat || bus.Apple_req !== do_eat) begin bad++;
                $display("FAIL eat_pulses it=%0d got add=%b req=%b want %b",
                         it, bus.Body_add_sig, bus.Apple_req, do_eat); end
            total++; if (bus.Score !== 8'(exp_score) || bus.Level !== 4'(exp_level)) begin bad++;
                $display("FAIL score_level it=%0d got %0d/%0d want %0d/%0d",
                         it, bus.Score, bus.Level, exp_score, exp_level); end
            if (bus.Game_status !== 3'b010) not_play++;
            wait_tick(n);
            total++; if (n + 1 !== exp_period) begin bad++;
                $display("FAIL period it=%0d got=%0d want=%0d", it, n + 1, exp_period); end
        end
        total++; if (bus.Score !== 8'd6 || bus.Level !== 4'd3) begin bad++;
            $display("FAIL six_eats got score=%0d level=%0d want 6/3", bus.Score, bus.Level); end
        total++; if (stray !== 0 || not_play !== 0) begin bad++;
            $display("FAIL eat_stray got pulses=%0d nonplay=%0d want 0/0", stray, not_play); end
    endtask

    task automatic test_collision();
        bus.Apple = 8'h35; bus.Head = 8'h35; bus.Apple_valid = 1'b1; bus.Hit_wall_sig = 1'b1;
        step();
        bus.Hit_wall_sig = 1'b0; bus.Apple_valid = 1'b0;
        total++; if (bus.Game_status !== 3'b100) begin bad++;
            $display("FAIL collide_status got=%b want=100", bus.Game_status); end
        total++; if (bus.Body_add_sig !== 1'b0 || bus.Apple_req !== 1'b0 ||
                     bus.Score !== 8'(exp_score)) begin bad++;
            $display("FAIL collide_no_eat got add=%b req=%b score=%0d want 0/0/%0d",
                     bus.Body_add_sig, bus.Apple_req, bus.Score, exp_score); end
    endtask

    task automatic test_end_flash();
        int n;
        int ticks;
        ticks = 0;
        bus.Key_start = 1'b0;
        total++; if (bus.Flash_sig !== 1'b0) begin bad++;
            $display("FAIL end_flash_init got=%b want=0", bus.Flash_sig); end
        n = 0;
        do begin step(); n++; if (bus.Move_tick) ticks++; end while (bus.Flash_sig !== 1'b1 && n < 50);
        total++; if (n !== FH) begin bad++;
            $display("FAIL flash_half1 got=%0d want=%0d", n, FH); end
        bus.Key_start = 1'b1;
        step();
        bus.Key_start = 1'b0;
        total++; if (bus.Game_status !== 3'b100) begin bad++;
            $display("FAIL early_press got=%b want=100", bus.Game_status); end
        n = 1;
        do begin step(); n++; if (bus.Move_tick) ticks++; end while (bus.Flash_sig !== 1'b0 && n < 50);
        total++; if (n !== FH) begin bad++;
            $display("FAIL flash_half2 got=%0d want=%0d", n, FH); end
        total++; if (ticks !== 0) begin bad++;
            $display("FAIL end_ticks got=%0d want=0", ticks); end
        bus.Key_start = 1'b1;
        step();
        total++; if (bus.Game_status !== 3'b001 || bus.Flash_sig !== 1'b0) begin bad++;
            $display("FAIL end_restart got status=%b flash=%b want 001/0",
                     bus.Game_status, bus.Flash_sig); end
    endtask

    task automatic test_win();
        int n;
        press();
        total++; if (bus.Score !== 8'd0 || bus.Level !== 4'd0 || bus.Apple_req !== 1'b1) begin bad++;
            $display("FAIL restart_clear got score=%0d level=%0d req=%b want 0/0/1",
                     bus.Score, bus.Level, bus.Apple_req); end
        bus.Snake_length = 8'(ML - 1);
        wait_tick(n);
        total++; if (n !== TB) begin bad++;
            $display("FAIL period_reload got=%0d want=%0d", n, TB); end
        bus.Apple = 8'h47; bus.Head = 8'h47; bus.Apple_valid = 1'b1;
        step();
        bus.Apple_valid = 1'b0; bus.Snake_length = 8'd2;
        total++; if (bus.Win !== 1'b1 || bus.Game_status !== 3'b100) begin bad++;
            $display("FAIL win got win=%b status=%b want 1/100", bus.Win, bus.Game_status); end
        total++; if (bus.Body_add_sig !== 1'b1 || bus.Apple_req !== 1'b0 || bus.Score !== 8'd1) begin
            bad++; $display("FAIL win_eat got add=%b req=%b score=%0d want 1/0/1",
                bus.Body_add_sig, bus.Apple_req, bus.Score); end
        bus.Key_start = 1'b0;
        repeat (12) step();
        press();
        total++; if (bus.Game_status !== 3'b001) begin bad++;
            $display("FAIL win_restart got=%b want=001", bus.Game_status); end
        press();
        total++; if (bus.Game_status !== 3'b010 || bus.Win !== 1'b0) begin bad++;
            $display("FAIL win_clear got status=%b win=%b want 010/0", bus.Game_status, bus.Win); end
    endtask

    task automatic test_mid_reset();
        int n;
        wait_tick(n);
        bus.Apple = 8'h5a; bus.Head = 8'h5a; bus.Apple_valid = 1'b1;
        step();
        bus.Apple_valid = 1'b0;
        total++; if (bus.Score !== 8'd1) begin bad++;
            $display("FAIL pre_reset_score got=%0d want=1", bus.Score); end
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (bus.Game_status !== 3'b001 || bus.Score !== 8'd0 || bus.Level !== 4'd0 ||
                     bus.Win !== 1'b0) begin bad++;
            $display("FAIL mid_reset_regs got status=%b score=%0d level=%0d win=%b want 001/0/0/0",
                     bus.Game_status, bus.Score, bus.Level, bus.Win); end
        total++; if ({bus.Move_tick, bus.Body_add_sig, bus.Apple_req, bus.Flash_sig} !== 4'b0) begin
            bad++; $display("FAIL mid_reset_pulses got=%b want=0000",
                {bus.Move_tick, bus.Body_add_sig, bus.Apple_req, bus.Flash_sig}); end
        press();
        wait_tick(n);
        total++; if (n !== TB) begin bad++;
            $display("FAIL post_reset_tick got=%0d want=%0d", n, TB); end
    endtask

    initial begin
        test_reset();
        test_eat();
        test_collision();
        test_end_flash();
        test_win();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
